// File: rtl/shift_add_multiplier.sv
// ----------------------------------------------------------------------------
// shift_add_multiplier
//
// Sequential shift-and-add multiplier. A request is accepted in IDLE and the
// operands are latched. CALC then retires one multiplier bit per cycle, LSB
// first, for exactly W cycles. The 2*W-bit result is loaded into `product` on
// the CALC->DONE edge. `done` is high for the single DONE cycle.
//
// Optional feature (compile-time macro):
//   MULT_SIGNED_EN - adds the `sgn` port. With sgn=1 the operands are two's
//                    complement. Magnitudes are multiplied, and the result is
//                    negated when it is loaded if the operand signs differ.
//
// Ports:
//   clk     - clock; all state changes on the rising edge
//   rst     - asynchronous, active-low reset
//   start   - multiply request, sampled only in IDLE
//   a, b    - multiplicand / multiplier (W bits), captured on acceptance
//   sgn     - signed-mode select (only with MULT_SIGNED_EN)
//   product - last completed 2*W-bit result, held between completions
//   busy    - high in CALC and DONE
//   done    - one-cycle pulse when product takes a new value
// ----------------------------------------------------------------------------
module shift_add_multiplier #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
`ifdef MULT_SIGNED_EN
    input  logic           sgn,
`endif
    output logic [2*W-1:0] product,
    output logic           busy,
    output logic           done
);

    localparam int PW = 2 * W;
    localparam int CW = $clog2(W + 1);  // counter reaches W without wrapping

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  mcand;       // latched multiplicand (magnitude in signed mode)
    logic [W-1:0]  mplier;      // latched multiplier, shifted right each iteration
    logic [W-1:0]  acc_hi;      // accumulator upper half
    logic [W-1:0]  acc_lo;      // accumulator lower half, filled by shifted-out bits
    logic [CW-1:0] cnt;         // completed iterations
    logic [W:0]    sum;         // upper half plus addend, including carry
    logic [PW-1:0] acc_nxt;     // accumulator after this iteration
    logic [PW-1:0] result;      // value loaded into product on the last iteration
    logic          last_iter;
    logic [W-1:0]  a_op, b_op;  // operands as they are latched

`ifdef MULT_SIGNED_EN
    logic          neg;         // result must be negated on load

    // -2^(W-1) negates to itself, which is the correct unsigned magnitude.
    always_comb begin
        a_op = (sgn && a[W-1]) ? (~a + W'(1)) : a;
        b_op = (sgn && b[W-1]) ? (~b + W'(1)) : b;
    end
`else
    always_comb begin
        a_op = a;
        b_op = b;
    end
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) assignments, so every
    // register samples pre-edge values no matter what order the blocks run in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // ------------------------------------------------------------------
    // Datapath: one add-and-shift per CALC cycle
    // ------------------------------------------------------------------
    always_comb begin
        sum       = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : {(W+1){1'b0}});
        // Shift right by one. The carry (sum[W]) moves into the top bit.
        acc_nxt   = {sum, acc_lo[W-1:1]};
        last_iter = (cnt == CW'(W - 1));
`ifdef MULT_SIGNED_EN
        result    = neg ? (~acc_nxt + PW'(1)) : acc_nxt;
`else
        result    = acc_nxt;
`endif
    end

    // NOTE: reset clears every register, including the operands and the
    // accumulator. An aborted operation therefore leaves nothing stale behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand   <= '0;
            mplier  <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            cnt     <= '0;
            product <= '0;
`ifdef MULT_SIGNED_EN
            neg     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a_op;
                        mplier <= b_op;
                        acc_hi <= '0;
                        acc_lo <= '0;
                        cnt    <= '0;
`ifdef MULT_SIGNED_EN
                        neg    <= sgn & (a[W-1] ^ b[W-1]);
`endif
                    end
                end
                CALC: begin
                    acc_hi <= acc_nxt[PW-1:W];
                    acc_lo <= acc_nxt[W-1:0];
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last_iter) product <= result;
                end
                default: ;  // DONE: everything holds
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// ----------------------------------------------------------------------------
// tb_shift_add_multiplier
//
// Scoreboard bench for shift_add_multiplier (W=8). Stimulus tasks push the
// expected product and the acceptance cycle into a queue when a request is
// accepted. A monitor process samples on the falling edge. Whenever done is
// high, it pops one entry and compares the product and the latency.
// ----------------------------------------------------------------------------
module tb_shift_add_multiplier;

    localparam int W = 8;

    typedef struct {
        logic [2*W-1:0] prod;
        int             cyc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
`ifdef MULT_SIGNED_EN
    logic           sgn_drv = 1'b0;
`endif
    logic [2*W-1:0] product;
    logic           busy;
    logic           done;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_done  = 0;
    int   n_check = 0;
    int   n_fail  = 0;

    shift_add_multiplier #(.W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
`ifdef MULT_SIGNED_EN
        .sgn     (sgn_drv),
`endif
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Rising-edge count. After edge n it reads n for the rest of that cycle.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_check++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    // Done is seen in the cycle after edge k+W, so it is sampled by edge k+W+1.
    always @(negedge clk) begin
        if (rst && done) begin
            n_done++;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("product", product, e.prod);
                check("latency", cyc - e.cyc, W);
                check("busy_in_done", busy, 1);
            end
        end
    end

    // Waits for busy to fall, with a cycle bound. Returns the busy cycles seen.
    task automatic wait_idle(output int busy_cycles);
        busy_cycles = 0;
        for (int i = 0; i < 4 * W; i++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cycles++;
        end
        check("reached_idle", busy, 0);
    endtask

    // A single request with start held for one cycle. The operand inputs are
    // scrambled while the operation runs. This must have no effect.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [2*W-1:0] exp_p, input bit rel_rst);
        int bc;
        int done0;
        @(negedge clk);
        if (rel_rst) rst = 1'b1;
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        check("accept", busy, 1);
        sb.push_back('{exp_p, cyc});
        done0 = n_done;
        @(negedge clk);
        start = 1'b0; a = ~av; b = ~bv;
        wait_idle(bc);
        check("busy_cycles", bc + 1, W + 1);  // the first negedge was consumed above
        check("one_done", n_done - done0, 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int bc;
        int done0;
        int last_acc;
        bit found;
        bit prev;
        logic [W-1:0]   ca [3];
        logic [W-1:0]   cb [3];
        logic [2*W-1:0] cp [3];

        // Reset state
        #3;
        check("rst_product", product, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        // The first start is accepted on the first edge after reset release.
        run_op(8'hFF, 8'hFF, 16'hFE01, 1'b1);
        run_op(8'h00, 8'hA5, 16'h0000, 1'b0);
        run_op(8'h0C, 8'h0A, 16'h0078, 1'b0);
        run_op(8'h01, 8'hFF, 16'h00FF, 1'b0);
        run_op(8'h80, 8'h02, 16'h0100, 1'b0);
        run_op(8'hAB, 8'hCD, 16'h88EF, 1'b0);

        // Start pulsed 3 cycles into CALC with other operands is ignored.
        @(negedge clk);
        a = 8'h12; b = 8'h34; start = 1'b1;
        @(posedge clk); #1;
        check("ign_accept", busy, 1);
        sb.push_back('{16'h03A8, cyc});
        done0 = n_done;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); start = 1'b1; a = 8'h55; b = 8'h66;
        @(negedge clk); start = 1'b0;
        wait_idle(bc);
        check("ign_one_done", n_done - done0, 1);

        // product holds while idle, even if the inputs change.
        a = 8'h77; b = 8'h99;
        repeat (5) @(negedge clk);
        check("hold_product", product, 16'h03A8);
        check("hold_busy", busy, 0);

        // Reset at iteration 4 of 0xFF*0xFF.
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(posedge clk); #1;
        check("abort_accept", busy, 1);
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        done0 = n_done;
        #2 rst = 1'b0;
        #1;
        check("abort_product", product, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_done", n_done - done0, 0);
        check("abort_product_after", product, 0);
        run_op(8'h0C, 8'h0A, 16'h0078, 1'b0);

        // start held high: one accept per IDLE visit, every W+2 cycles.
        ca = '{8'h03, 8'h10, 8'hFF};
        cb = '{8'h05, 8'h10, 8'h01};
        cp = '{16'h000F, 16'h0100, 16'h00FF};
        done0 = n_done;
        last_acc = 0;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = ca[i]; b = cb[i];
            found = 1'b0;
            for (int j = 0; j < 4 * W; j++) begin
                prev = busy;
                @(posedge clk); #1;
                if (busy && !prev) begin
                    found = 1'b1;
                    break;
                end
            end
            check("cont_accept", found, 1);
            if (found) begin
                sb.push_back('{cp[i], cyc});
                if (i > 0) check("cont_period", cyc - last_acc, W + 2);
                last_acc = cyc;
            end
        end
        @(negedge clk); start = 1'b0;
        wait_idle(bc);
        check("cont_done_count", n_done - done0, 3);

`ifdef MULT_SIGNED_EN
        sgn_drv = 1'b1;
        run_op(8'h80, 8'h80, 16'h4000, 1'b0);
        run_op(8'hFD, 8'h05, 16'hFFF1, 1'b0);
        sgn_drv = 1'b0;
        run_op(8'hFD, 8'h05, 16'h04F1, 1'b0);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule
